// File: rtl/ka_pkg.sv
// Shared Karatsuba definitions: operand widths, beat tag encoding and issue states.
// Used by the split/issue block and by the overlap combiner that consumes its beats.
package ka_pkg;

  localparam int N      = 50;
  localparam int OP_W   = N - 1;
  localparam int HALF_W = N / 2;

  // Tag values name the combiner input a beat's product is routed to
  localparam logic [1:0] TAG_LOW  = 2'd0;
  localparam logic [1:0] TAG_MID  = 2'd1;
  localparam logic [1:0] TAG_HIGH = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_MID  = 2'd3
  } issue_state_e;

endpackage

// File: rtl/ka_half_split_49bit.sv
// Splits one GF(2) operand into low half, zero-extended high half and their XOR.
// Purely combinational; one instance per operand.
module ka_half_split_49bit #(
  parameter int n = 50
) (
  input  logic [n-2:0]   op,
  output logic [n/2-1:0] lo,
  output logic [n/2-1:0] hi,
  output logic [n/2-1:0] mid
);

  localparam int h_w  = n / 2;
  localparam int hi_w = n - 1 - h_w;

  always_comb begin
    lo             = op[h_w-1:0];
    hi             = '0;
    hi[hi_w-1:0]   = op[n-2:h_w];
    mid            = lo ^ hi;
  end

endmodule

// File: rtl/ka_split_issue_49bit.sv
// Karatsuba decomposition issue stage: latches an operand pair and issues low, high
// and middle sub-products as three tagged beats. Macro KA_SPLIT_PRELOAD_EN lets a
// new pair be accepted on the MID handshake for one operation every 3 cycles.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for an operand pair, in_ready=1
// LOW     | issuing lo(A) x lo(B), tag LOW
// HIGH    | issuing hi(A) x hi(B), tag HIGH
// MID     | issuing mid(A) x mid(B), tag MID, last beat of the operation
module ka_split_issue_49bit
  import ka_pkg::*;
#(
  parameter int n = N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [n-2:0]   A_in,
  input  logic [n-2:0]   B_in,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [n/2-1:0] X_out,
  output logic [n/2-1:0] Y_out,
  output logic [1:0]     tag_out,
  output logic           last_out,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int op_w = n - 1;
  localparam int h_w  = n / 2;

  issue_state_e    state_q, state_d;
  logic [op_w-1:0] a_q, b_q;
  logic [h_w-1:0]  a_lo, a_hi, a_mid;
  logic [h_w-1:0]  b_lo, b_hi, b_mid;
  logic            accept;
  logic            beat_done;

  assign accept    = in_valid && in_ready;
  assign beat_done = out_valid && out_ready;

  ka_half_split_49bit #(.n(n)) u_split_a (
    .op  (a_q),
    .lo  (a_lo),
    .hi  (a_hi),
    .mid (a_mid)
  );

  ka_half_split_49bit #(.n(n)) u_split_b (
    .op  (b_q),
    .lo  (b_lo),
    .hi  (b_hi),
    .mid (b_mid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operands are only captured on accept, so later A_in/B_in activity is invisible
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      a_q <= A_in;
      b_q <= B_in;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_LOW;
      ST_LOW:  if (beat_done) state_d = ST_HIGH;
      ST_HIGH: if (beat_done) state_d = ST_MID;
      ST_MID:  if (beat_done) state_d = accept ? ST_LOW : ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    X_out     = '0;
    Y_out     = '0;
    tag_out   = TAG_LOW;
    last_out  = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_LOW: begin
        out_valid = 1'b1;
        X_out     = a_lo;
        Y_out     = b_lo;
        tag_out   = TAG_LOW;
      end
      ST_HIGH: begin
        out_valid = 1'b1;
        X_out     = a_hi;
        Y_out     = b_hi;
        tag_out   = TAG_HIGH;
      end
      ST_MID: begin
        out_valid = 1'b1;
        X_out     = a_mid;
        Y_out     = b_mid;
        tag_out   = TAG_MID;
        last_out  = 1'b1;
`ifdef KA_SPLIT_PRELOAD_EN
        in_ready  = out_ready;
`else
        in_ready  = 1'b0;
`endif
      end
      default: in_ready = 1'b0;
    endcase
    // Reset masks the interface immediately so no beat or accept leaks through
    if (rst) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      X_out     = '0;
      Y_out     = '0;
      tag_out   = TAG_LOW;
      last_out  = 1'b0;
    end
  end

endmodule

// File: tb/tb_ka_split_issue_49bit.sv
// Self-checking bench for ka_split_issue_49bit: directed protocol steps, then random
// operations recombined as the overlap combiner would and compared to a GF(2) product.
module tb_ka_split_issue_49bit;

  localparam int NUM_OPS = 10000;

  logic        clk;
  logic        rst;
  logic [48:0] A_in, B_in;
  logic        in_valid, in_ready;
  logic [24:0] X_out, Y_out;
  logic [1:0]  tag_out;
  logic        last_out, out_valid, out_ready;

  int tests = 0;
  int fails = 0;

  ka_split_issue_49bit #(.n(50)) dut (
    .clk       (clk),
    .rst       (rst),
    .A_in      (A_in),
    .B_in      (B_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X_out     (X_out),
    .Y_out     (Y_out),
    .tag_out   (tag_out),
    .last_out  (last_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Reference halves: low 25 bits, the remaining 24 bits, and their carry-free sum
  function automatic logic [24:0] part(input logic [48:0] v, input int pos);
    logic [48:0] lo, hi;
    lo = v % 49'h2000000;
    hi = v / 49'h2000000;
    if (pos == 0) return lo[24:0];
    if (pos == 1) return hi[24:0];
    return lo[24:0] ^ hi[24:0];
  endfunction

  function automatic logic [1:0] pos_tag(input int pos);
    return (pos == 0) ? 2'd0 : (pos == 1) ? 2'd2 : 2'd1;
  endfunction

  function automatic logic [96:0] clmul(input logic [48:0] a, input logic [48:0] b);
    logic [96:0] r;
    r = '0;
    for (int i = 0; i < 49; i++)
      if (b[i]) r = r ^ ({48'b0, a} << i);
    return r;
  endfunction

  task automatic check_beat(input string name, input logic v, input logic [24:0] x,
                            input logic [24:0] y, input logic [1:0] t, input logic l);
    chk({name, "_valid"}, 128'(out_valid), 128'(v));
    chk({name, "_x"},     128'(X_out),     128'(x));
    chk({name, "_y"},     128'(Y_out),     128'(y));
    chk({name, "_tag"},   128'(tag_out),   128'(t));
    chk({name, "_last"},  128'(last_out),  128'(l));
  endtask

  initial begin
    logic [48:0] ea, eb, ra, rb;
    logic [48:0] ba [2];
    logic [48:0] bb [2];
    logic [63:0] r64;
    logic [8:0]  exp_pat;
    logic [24:0] bx [3];
    logic [24:0] by [3];
    logic [1:0]  bt [3];
    logic        bl [3];
    logic [24:0] hx, hy;
    logic [1:0]  ht;
    logic        hl, hold, accepted;
    logic [96:0] p0, p2, pm, rec;
    int          acc, k, got, cyc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A_in = '0; B_in = '0;
    repeat (2) @(negedge clk);
    #1;
    check_beat("reset", 1'b0, 25'h0, 25'h0, 2'd0, 1'b0);

    @(negedge clk); rst = 1'b0; #1;
    chk("in_ready_after_rst", 128'(in_ready), 128'(1));

    // Fixed vector with known split results
    A_in = 49'h2000001; B_in = 49'h1FFFFFFFFFFFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; A_in = 49'h0AAAAAAAAAAAA; B_in = 49'h1555555555555; #1;
    check_beat("vec_low", 1'b1, 25'h1, 25'h1FFFFFF, 2'd0, 1'b0);
    chk("vec_low_in_ready", 128'(in_ready), 128'(0));
    @(negedge clk); #1;
    check_beat("vec_high", 1'b1, 25'h1, 25'h0FFFFFF, 2'd2, 1'b0);
    chk("vec_high_in_ready", 128'(in_ready), 128'(0));
    @(negedge clk); #1;
    check_beat("vec_mid", 1'b1, 25'h0, 25'h1000000, 2'd1, 1'b1);
    @(negedge clk); #1;
    check_beat("vec_idle", 1'b0, 25'h0, 25'h0, 2'd0, 1'b0);
    chk("vec_idle_in_ready", 128'(in_ready), 128'(1));

    // Five-cycle stall on the HIGH beat
    r64 = {$urandom, $urandom}; ea = r64[48:0];
    r64 = {$urandom, $urandom}; eb = r64[48:0];
    A_in = ea; B_in = eb; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0; #1;
    check_beat("stall_low", 1'b1, part(ea, 0), part(eb, 0), 2'd0, 1'b0);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk); out_ready = 1'b0; #1;
      check_beat("stall_high_held", 1'b1, part(ea, 1), part(eb, 1), 2'd2, 1'b0);
    end
    @(negedge clk); out_ready = 1'b1; #1;
    check_beat("stall_high_release", 1'b1, part(ea, 1), part(eb, 1), 2'd2, 1'b0);
    @(negedge clk); #1;
    check_beat("stall_mid", 1'b1, part(ea, 2), part(eb, 2), 2'd1, 1'b1);
    @(negedge clk); #1;
    chk("stall_done_valid", 128'(out_valid), 128'(0));

    // Two pairs offered back to back
`ifdef KA_SPLIT_PRELOAD_EN
    exp_pat = 9'b001111110;
`else
    exp_pat = 9'b011101110;
`endif
    for (int i = 0; i < 2; i++) begin
      r64 = {$urandom, $urandom}; ba[i] = r64[48:0];
      r64 = {$urandom, $urandom}; bb[i] = r64[48:0];
    end
    acc = 0; k = 0;
    A_in = ba[0]; B_in = bb[0]; in_valid = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (acc < 2) begin
          A_in = ba[acc]; B_in = bb[acc]; in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      #1;
      chk("b2b_valid", 128'(out_valid), 128'(exp_pat[c]));
      if (out_valid && k < 6) begin
        check_beat("b2b_beat", 1'b1, part(ba[k/3], k%3), part(bb[k/3], k%3),
                   pos_tag(k%3), (k%3 == 2));
        k++;
      end
      if (in_valid && in_ready) acc++;
    end
    chk("b2b_beat_count", 128'(k), 128'(6));

    // Reset while the HIGH beat is pending
    @(negedge clk);
    r64 = {$urandom, $urandom}; ea = r64[48:0];
    A_in = ea; B_in = ~ea; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); #1;
    chk("rst_pre_tag", 128'(tag_out), 128'(2));
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_valid_cleared", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    r64 = {$urandom, $urandom}; ea = r64[48:0];
    r64 = {$urandom, $urandom}; eb = r64[48:0];
    A_in = ea; B_in = eb; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0; #1;
    check_beat("rst_fresh_low", 1'b1, part(ea, 0), part(eb, 0), 2'd0, 1'b0);
    @(negedge clk); @(negedge clk); @(negedge clk); #1;
    chk("rst_fresh_done", 128'(out_valid), 128'(0));

    // Random operations with random back-pressure, recombined Karatsuba-style
    hx = '0; hy = '0; ht = '0; hl = 1'b0;
    for (int op = 0; op < NUM_OPS; op++) begin
      @(negedge clk);
      r64 = {$urandom, $urandom}; ra = r64[48:0];
      r64 = {$urandom, $urandom}; rb = r64[48:0];
      A_in = ra; B_in = rb; in_valid = 1'b1;
      out_ready = ($urandom_range(3) != 0);
      accepted = 1'b0; hold = 1'b0; got = 0; cyc = 0;
      while (got < 3 && cyc < 64) begin
        #1;
        if (hold)
          chk("rand_stall_hold", 128'({out_valid, X_out, Y_out, tag_out, last_out}),
              128'({1'b1, hx, hy, ht, hl}));
        if (!out_valid)
          chk("rand_idle_zero", 128'({X_out, Y_out, tag_out, last_out}), 128'(0));
        hold = out_valid && !out_ready;
        hx = X_out; hy = Y_out; ht = tag_out; hl = last_out;
        if (out_valid && out_ready) begin
          bx[got] = X_out; by[got] = Y_out; bt[got] = tag_out; bl[got] = last_out;
          got++;
        end
        if (!accepted && in_valid && in_ready) accepted = 1'b1;
        if (got < 3) begin
          @(negedge clk);
          cyc++;
          if (accepted) begin
            in_valid = 1'b0;
            r64 = {$urandom, $urandom}; A_in = r64[48:0];
            r64 = {$urandom, $urandom}; B_in = r64[48:0];
          end
          out_ready = ($urandom_range(3) != 0);
        end
      end
      if (got != 3) begin
        chk("rand_beat_timeout", 128'(got), 128'(3));
        break;
      end
      chk("rand_tag_order", 128'({bt[0], bt[1], bt[2]}), 128'(6'b00_10_01));
      chk("rand_last_flags", 128'({bl[0], bl[1], bl[2]}), 128'(3'b001));
      p0  = clmul({24'b0, bx[0]}, {24'b0, by[0]});
      p2  = clmul({24'b0, bx[1]}, {24'b0, by[1]});
      pm  = clmul({24'b0, bx[2]}, {24'b0, by[2]});
      rec = p0 ^ ((pm ^ p0 ^ p2) << 25) ^ (p2 << 50);
      chk("rand_product", 128'(rec), 128'(clmul(ra, rb)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
